// File: rtl/nonce_seed_arbiter.sv
// nonce_seed_arbiter
// Shares one free-running 27-trit (54-bit) random source among NUM_REQ PoW
// workers. Grants are round-robin and spaced at least GAP cycles apart, so
// every seed is built from bits the source has not shown before. Illegal
// trit codes (2'b10) are cleared to 2'b00 and flagged.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_enable     allows grants; the cooldown counter keeps running when low
//   i_rnd_trits  random trit word, trit k = {bit 2k+1, bit 2k}
//   i_req        level request per worker, held until its grant is seen
//   o_gnt        one-hot single-cycle grant pulse (registered)
//   o_seed       sanitised seed, loaded on each grant and held until the next
//   o_seed_valid high for exactly the o_gnt cycle
//   o_bad_trit   sticky flag: an illegal code was sampled into a seed
//   o_ready      cooldown expired (decoded from the state register)
module nonce_seed_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP     = 54
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [53:0]        i_rnd_trits,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [53:0]        o_seed,
  output logic               o_seed_valid,
  output logic               o_bad_trit,
  output logic               o_ready
);

  localparam int                 PTR_W = $clog2(NUM_REQ);
  localparam logic [7:0]         GAP_C = 8'(GAP);
  localparam logic [NUM_REQ-1:0] ONE_C = NUM_REQ'(1);

  typedef enum logic [0:0] {
    ST_COOLDOWN = 1'b0,
    ST_READY    = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [7:0]       cnt_r, cnt_next_s;
  logic [PTR_W-1:0] ptr_r, ptr_next_s, winner_s;
  logic             grant_s;
  logic [53:0]      clean_s;
  logic             bad_s;

  // Clear every 2'b10 trit to 2'b00; legal codes pass unchanged.
  function automatic logic [53:0] sanitise(input logic [53:0] w);
    logic [53:0] r;
    r = w;
    for (int k = 0; k < 27; k++) begin
      if (w[2*k +: 2] == 2'b10) r[2*k +: 2] = 2'b00;
      else                      r[2*k +: 2] = w[2*k +: 2];
    end
    return r;
  endfunction

  // True when any trit of the word carries the illegal 2'b10 code.
  function automatic logic has_bad(input logic [53:0] w);
    logic b;
    b = 1'b0;
    for (int k = 0; k < 27; k++) begin
      b = b | (w[2*k +: 2] == 2'b10);
    end
    return b;
  endfunction

  // Round-robin pick: rotate the request vector so ptr lands at bit 0, take
  // the lowest set bit, then rotate the offset back into requester space.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] rot;
    logic [PTR_W-1:0]   off;
    logic [PTR_W:0]     sum;
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = PTR_W'(i);
      else        off = off;
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    else                            sum = sum;
    return sum[PTR_W-1:0];
  endfunction

  // State register: FSM state, cooldown counter and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_COOLDOWN;
      cnt_r   <= 8'd0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Next-state logic. READY is exactly "counter at GAP", which also covers
  // GAP=1 where the post-grant load of 1 is already the expired value.
  always_comb begin
    cnt_next_s = cnt_r;
    ptr_next_s = ptr_r;
    case (state_r)
      ST_COOLDOWN: begin
        if (cnt_r < GAP_C) cnt_next_s = cnt_r + 8'd1;
        else               cnt_next_s = cnt_r;
      end
      ST_READY: begin
        if (grant_s) begin
          cnt_next_s = 8'd1;
          if (winner_s == PTR_W'(NUM_REQ - 1)) ptr_next_s = '0;
          else                                 ptr_next_s = winner_s + PTR_W'(1);
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        cnt_next_s = 8'd0;
        ptr_next_s = '0;
      end
    endcase
    if (cnt_next_s == GAP_C) state_next_s = ST_READY;
    else                     state_next_s = ST_COOLDOWN;
  end

  // Output decode: ready flag, grant decision, winner and sanitised word.
  always_comb begin
    o_ready  = (state_r == ST_READY);
    winner_s = rr_pick(i_req, ptr_r);
    grant_s  = o_ready && i_enable && (|i_req);
    clean_s  = sanitise(i_rnd_trits);
    bad_s    = has_bad(i_rnd_trits);
  end

  // Registered grant, seed and sticky bad-trit outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt        <= '0;
      o_seed       <= 54'd0;
      o_seed_valid <= 1'b0;
      o_bad_trit   <= 1'b0;
    end else begin
      o_seed_valid <= grant_s;
      if (grant_s) begin
        o_gnt      <= ONE_C << winner_s;
        o_seed     <= clean_s;
        o_bad_trit <= o_bad_trit | bad_s;
      end else begin
        o_gnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nonce_seed_arbiter.sv
// tb_nonce_seed_arbiter
// Self-checking bench for nonce_seed_arbiter (NUM_REQ=4, GAP=54). A cycle
// model tracks "cycles since the last grant decision" and a round-robin
// pointer as plain integers and predicts every output each cycle; directed
// scenarios add explicit checks of cycle numbers and grant order.
module tb_nonce_seed_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 54;

  logic            clk;
  logic            rst;
  logic            en;
  logic [53:0]     rnd;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] o_gnt;
  logic [53:0]     o_seed;
  logic            o_seed_valid;
  logic            o_bad_trit;
  logic            o_ready;

  logic [NREQ+56:0] act_all;
  logic [NREQ+56:0] exp_all;

  int vec = 0;
  int err = 0;

  // model state: cycle index since reset release, cycle of last grant decision
  int              cyc;
  int              anchor;
  int              m_ptr;
  logic [NREQ-1:0] e_gnt;
  logic            e_valid;
  logic            e_ready;
  logic            e_bad;
  logic [53:0]     e_seed;

  nonce_seed_arbiter #(.NUM_REQ(NREQ), .GAP(GAP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_rnd_trits  (rnd),
    .i_req        (req),
    .o_gnt        (o_gnt),
    .o_seed       (o_seed),
    .o_seed_valid (o_seed_valid),
    .o_bad_trit   (o_bad_trit),
    .o_ready      (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_all = {o_gnt, o_seed_valid, o_ready, o_bad_trit, o_seed};

  function automatic logic [53:0] legal_rnd();
    logic [53:0] w;
    int r;
    w = 54'd0;
    for (int k = 0; k < 27; k++) begin
      r = $urandom_range(0, 2);
      w[2*k +: 2] = (r == 2) ? 2'b11 : ((r == 1) ? 2'b01 : 2'b00);
    end
    return w;
  endfunction

  function automatic logic [53:0] any_rnd();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[53:0];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Apply the current inputs for one cycle: predict the result of this
  // cycle's edge, advance the clock, and land #1 into the next cycle.
  task automatic tick();
    int          win;
    int          idx;
    logic        bad;
    logic [53:0] s;
    if (rst) begin
      cyc = 0; anchor = 0; m_ptr = 0;
      e_gnt = '0; e_valid = 1'b0; e_bad = 1'b0; e_seed = 54'd0;
    end else begin
      win = -1;
      if ((cyc - anchor) >= GAP && en) begin
        for (int i = 0; i < NREQ; i++) begin
          idx = (m_ptr + i) % NREQ;
          if (win < 0 && req[idx]) win = idx;
        end
      end
      if (win >= 0) begin
        s = rnd; bad = 1'b0;
        for (int k = 0; k < 27; k++) begin
          if (rnd[2*k +: 2] == 2'b10) begin
            s[2*k +: 2] = 2'b00;
            bad = 1'b1;
          end
        end
        e_gnt   = '0;
        e_gnt[win] = 1'b1;
        e_valid = 1'b1;
        e_seed  = s;
        e_bad   = e_bad | bad;
        m_ptr   = (win + 1) % NREQ;
        anchor  = cyc;
      end else begin
        e_gnt   = '0;
        e_valid = 1'b0;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    e_ready = ((cyc - anchor) >= GAP);
    exp_all = {e_gnt, e_valid, e_ready, e_bad, e_seed};
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = '0; rnd = 54'd0;
    for (int n = 0; n < 2; n++) begin
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
    end
    vec++;
    if (act_all !== '0) begin
      err++; $display("FAIL reset_zero got=%h want=0", act_all);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_spacing();
    int          first_rdy;
    int          first_gnt;
    logic [3:0]  gval;
    logic [53:0] sval;
    logic [53:0] want_seed;
    first_rdy = -1; first_gnt = -1; gval = '0; sval = 54'd0; want_seed = 54'd0;
    en = 1'b1; req = 4'b0001;
    for (int n = 0; n < 70 && first_gnt < 0; n++) begin
      rnd = legal_rnd();
      if (cyc == 54) want_seed = rnd;
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL spacing_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_ready && first_rdy < 0) first_rdy = cyc;
      if (o_gnt != 0 && first_gnt < 0) begin
        first_gnt = cyc; gval = o_gnt; sval = o_seed;
      end
    end
    req = '0;
    vec++;
    if (first_rdy != 54) begin err++; $display("FAIL spacing_ready_cycle got=%0d want=54", first_rdy); end
    vec++;
    if (first_gnt != 55) begin err++; $display("FAIL spacing_gnt_cycle got=%0d want=55", first_gnt); end
    vec++;
    if (gval !== 4'b0001) begin err++; $display("FAIL spacing_gnt got=%b want=0001", gval); end
    vec++;
    if (sval !== want_seed) begin err++; $display("FAIL spacing_seed got=%h want=%h", sval, want_seed); end
  endtask

  task automatic test_round_robin();
    int ng;
    int g_idx [5];
    int g_cyc [5];
    int want  [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; tick(); rst = 1'b0;
    ng = 0; en = 1'b1; req = 4'b1111;
    for (int n = 0; n < 5 * GAP + 20 && ng < 5; n++) begin
      rnd = any_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) begin
        vec++;
        if (!$onehot(o_gnt)) begin err++; $display("FAIL rr_onehot got=%b want=onehot", o_gnt); end
        g_idx[ng] = onehot_idx(o_gnt); g_cyc[ng] = cyc; ng++;
      end
    end
    req = '0;
    vec++;
    if (ng != 5) begin
      err++; $display("FAIL rr_count got=%0d want=5", ng);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vec++;
        if (g_idx[i] != want[i]) begin err++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, g_idx[i], want[i]); end
        if (i > 0) begin
          vec++;
          if (g_cyc[i] - g_cyc[i-1] != GAP) begin
            err++; $display("FAIL rr_gap[%0d] got=%0d want=%0d", i, g_cyc[i] - g_cyc[i-1], GAP);
          end
        end
      end
    end
  endtask

  task automatic test_skip_idle();
    int ng;
    int g_idx [3];
    int want  [3] = '{3, 0, 3};
    bit seen;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; req = 4'b0001; seen = 1'b0;
    for (int n = 0; n < 70 && !seen; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL skip_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) seen = 1'b1;
    end
    vec++;
    if (!seen) begin err++; $display("FAIL skip_setup_gnt got=none want=grant"); end
    req = 4'b1001; ng = 0;
    for (int n = 0; n < 3 * GAP + 20 && ng < 3; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL skip_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) begin g_idx[ng] = onehot_idx(o_gnt); ng++; end
    end
    req = '0;
    vec++;
    if (ng != 3) begin
      err++; $display("FAIL skip_count got=%0d want=3", ng);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (g_idx[i] != want[i]) begin err++; $display("FAIL skip_order[%0d] got=%0d want=%0d", i, g_idx[i], want[i]); end
      end
    end
  endtask

  task automatic test_sanitise();
    bit seen;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; req = 4'b0001; rnd = 54'h2; seen = 1'b0;
    for (int n = 0; n < 70 && !seen; n++) begin
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL san_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) seen = 1'b1;
    end
    vec++;
    if (!seen || o_seed !== 54'h0 || o_bad_trit !== 1'b1) begin
      err++; $display("FAIL san_seed got=%h bad=%b want=0 bad=1", o_seed, o_bad_trit);
    end
    // a second grant with unrestricted random codes
    req = 4'b0010;
    for (int n = 0; n < 60; n++) begin
      rnd = any_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL san_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) req = '0;
    end
    vec++;
    if (o_bad_trit !== 1'b1) begin err++; $display("FAIL san_sticky got=%b want=1", o_bad_trit); end
    rst = 1'b1; tick(); rst = 1'b0;
    vec++;
    if (o_bad_trit !== 1'b0) begin err++; $display("FAIL san_clear got=%b want=0", o_bad_trit); end
  endtask

  task automatic test_enable();
    en = 1'b0; req = 4'b0010;
    for (int n = 0; n < 70 && !o_ready; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL en_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
    end
    for (int n = 0; n < 100; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (o_gnt !== 4'b0000 || o_ready !== 1'b1) begin
        err++; $display("FAIL en_hold cyc=%0d got gnt=%b rdy=%b want gnt=0000 rdy=1", cyc, o_gnt, o_ready);
      end
    end
    en = 1'b1;
    tick();
    vec++;
    if (o_gnt !== 4'b0010) begin err++; $display("FAIL en_release got=%b want=0010", o_gnt); end
    vec++;
    if (act_all !== exp_all) begin
      err++; $display("FAIL en_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
    end
  endtask

  task automatic test_reset_mid();
    int         first_gnt;
    logic [3:0] gval;
    req = 4'b0100; en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL mid_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    vec++;
    if (act_all !== '0) begin err++; $display("FAIL mid_reset_zero got=%h want=0", act_all); end
    req = 4'b1111; first_gnt = -1; gval = '0;
    for (int n = 0; n < 70 && first_gnt < 0; n++) begin
      rnd = legal_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL mid_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
      if (o_gnt != 0) begin first_gnt = cyc; gval = o_gnt; end
    end
    req = '0;
    vec++;
    if (first_gnt != 55) begin err++; $display("FAIL mid_gnt_cycle got=%0d want=55", first_gnt); end
    vec++;
    if (gval !== 4'b0001) begin err++; $display("FAIL mid_ptr_zero got=%b want=0001", gval); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 9) != 0);
      req = NREQ'($urandom_range(0, 15));
      rnd = any_rnd();
      tick();
      vec++;
      if (act_all !== exp_all) begin
        err++; $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, act_all, exp_all);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; rnd = 54'd0;
    cyc = 0; anchor = 0; m_ptr = 0;
    e_gnt = '0; e_valid = 1'b0; e_ready = 1'b0; e_bad = 1'b0; e_seed = 54'd0;
    exp_all = '0;
    test_reset();
    test_reset_spacing();
    test_round_robin();
    test_skip_idle();
    test_sanitise();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/nonce_seed_arbiter.md
# nonce_seed_arbiter

Shares one free-running 27-trit random source (54-bit, two bits per trit) among NUM_REQ PoW worker units that each need a fresh nonce seed. Requesters are served round-robin. A cooldown counter enforces a minimum spacing of GAP cycles between grants, so that consecutive seeds never overlap in shifted source bits. The block sits between the random-trit generator and the Curl/PoW worker array, and also sanitises illegal trit encodings.

## Interface
- NUM_REQ, 4, number of requesting worker units (2..16)
- GAP, 54, minimum cycles between consecutive grants; equal to source width, so every seed is made entirely of new bits (1..255)
- i_clk  input  1  clock; all logic is rising-edge
- i_rst  input  1  synchronous reset, active-high
- i_enable  input  1  grants are allowed only while this is high; the cooldown counter keeps running while it is low
- i_rnd_trits  input  54  random trit word; trit k = {bit 2k+1, bit 2k}; legal codes are 00, 01, 11
- i_req  input  NUM_REQ  level request per worker; the worker holds it until it sees its grant
- o_gnt  output  NUM_REQ  one-hot, single-cycle grant pulse
- o_seed  output  54  registered seed; valid in the o_gnt cycle and held until the next grant
- o_seed_valid  output  1  high for exactly the o_gnt cycle
- o_bad_trit  output  1  sticky: at least one illegal 2'b10 code was sampled since reset
- o_ready  output  1  high when the cooldown has expired, i.e. a grant is possible if i_enable=1 and a request is present

## Operation
- FSM has two states.
  - COOLDOWN: cnt < GAP; no grants are issued.
  - READY: cnt == GAP.
- COOLDOWN -> READY when cnt reaches GAP.
- READY -> COOLDOWN on a grant edge; at that edge cnt loads 1.
- cnt is 8 bits. It increments by 1 per cycle in COOLDOWN and saturates at GAP. It never wraps.
- Grant decision (combinational, cycle t): the state is READY, i_enable=1, and |i_req=1. Winner = first set bit of i_req scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- Grant edge, i.e. the end of cycle t:
  - o_gnt <= onehot(winner)
  - o_seed_valid <= 1
  - o_seed <= sanitised i_rnd_trits, as sampled in cycle t
  - ptr <= (winner+1) mod NUM_REQ
- Sanitising: each trit whose pair equals 2'b10 becomes 2'b00, and o_bad_trit sets. All other pairs pass through unchanged.
- Simultaneous requests: only the winner is granted. The losers stay pending and are served in later READY windows in round-robin order, so no requester waits more than NUM_REQ grants.
- A request withdrawn before its grant is simply not served. A request that arrives during COOLDOWN is held off; the block stores nothing.
- i_enable low while READY: the FSM stays READY, no grant is issued, and the pointer does not change.
- Reset, including mid-cooldown or in a grant cycle, forces:
  - state = COOLDOWN, cnt = 0, ptr = 0
  - o_gnt = 0, o_seed_valid = 0, o_seed = 0, o_bad_trit = 0
  - o_ready = 0

## Timing
- All outputs are registered, except o_ready, which decodes the state register.
- Request-to-grant latency: 1 cycle when READY, i.e. i_req high in cycle t gives o_gnt in cycle t+1.
- After reset deasserts (first cycle with i_rst=0 is cycle 0):
  - cnt=0 in cycle 0 and reaches GAP in cycle GAP; o_ready is high from cycle GAP.
  - The earliest o_gnt is cycle GAP+1.
- Grant spacing:
  - Back-to-back o_gnt pulses are exactly GAP cycles apart under continuous requests.
  - o_ready drops in the grant cycle and rises again GAP-1 cycles later.
- o_seed holds its value while o_seed_valid=0.

## Test plan
- **Reset spacing:** reset, then i_req=4'b0001 held with i_enable=1 -> o_ready rises in cycle 54 and o_gnt=4'b0001 in cycle 55, with o_seed equal to i_rnd_trits of cycle 54.
- **Round-robin under contention:** i_req=4'b1111 held -> grant order 0, 1, 2, 3, 0, with o_gnt pulses exactly 54 cycles apart and no cycle having two grant bits set.
- **Skip of idle requester:** ptr=1 and i_req=4'b1001 -> grant to 3, then to 0, then to 3.
- **Sanitising:** drive i_rnd_trits=54'h2 (trit 0 = 2'b10) at a grant -> o_seed=54'h0, and o_bad_trit=1 stays high until i_rst.
- **Enable gating:** hold i_enable=0 for 100 cycles while i_req=4'b0010 -> no grant and o_ready=1 stays high; raise i_enable -> o_gnt=4'b0010 one cycle later.
- **Reset mid-cooldown:** assert i_rst for 1 cycle 20 cycles after a grant -> all outputs return to 0, ptr=0, and the next grant comes no earlier than cycle 55 after release.
